fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, instruction address width in bits.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port imem_req  output  1  instruction memory read request.
REQ-006 Port imem_addr  output  ADDR_W  read address, SHALL be stable while imem_req=1 and imem_ack=0.
REQ-007 Port imem_ack  input  1  read data valid this cycle, ignored when imem_req=0.
REQ-008 Port imem_rdata  input  16  instruction word.
REQ-009 Port redirect_valid  input  1  one-cycle branch/jump redirect pulse.
REQ-010 Port redirect_pc  input  ADDR_W  redirect target.
REQ-011 Port inst_valid  output  1  decoded fields valid to the ControlUnit stage.
REQ-012 Port inst_ready  input  1  downstream accepts the instruction.
REQ-013 Port opcode  output  4  imem_rdata[15:12], feeds ControlUnit opcode.
REQ-014 Ports rd, rs1, rs2  output  4 each  imem_rdata[11:8], [7:4], [3:0].
REQ-015 Port inst_pc  output  ADDR_W  address of the presented instruction.

Function
REQ-016 FSM states: IDLE, REQ, HOLD, plus HALT when FETCH_HALT_EN is defined.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 In REQ, imem_req=1 and imem_addr=pc; on imem_ack, capture the word into the instruction register and go to HOLD.
REQ-019 Latency: imem_ack in cycle N SHALL give inst_valid=1 with that word's fields in cycle N+1.
REQ-020 In HOLD, inst_valid=1 and all outputs SHALL be held stable until inst_valid & inst_ready.
REQ-021 On handshake, pc SHALL become pc+1 modulo 2^ADDR_W (all-ones wraps to 0), and the FSM SHALL go to REQ.
REQ-022 Redirect in IDLE or HOLD: pc <= redirect_pc, inst_valid drops next cycle, go to REQ; a handshake in the same cycle completes but the increment is overridden by the redirect.
REQ-023 Redirect in REQ without ack: set kill flag, keep imem_addr unchanged, and latch redirect_pc as pc.
REQ-024 While kill=1, the acked word SHALL be discarded, kill cleared, and a new request issued at the redirected pc the next cycle.
REQ-025 Redirect in REQ coincident with ack: discard the word and re-request at redirect_pc next cycle.
REQ-026 inst_valid SHALL never be asserted for a killed or discarded word.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, pc=RESET_PC, kill=0, imem_req=0, inst_valid=0, opcode/rd/rs1/rs2=0, inst_pc=RESET_PC.
REQ-028 Reset mid-request SHALL abandon the transaction; an imem_ack after reset release with no outstanding request SHALL be ignored.

Configuration
REQ-029 Macro FETCH_HALT_EN: when defined, a handshaked instruction with opcode 4'b1111 sends the FSM to HALT (imem_req=0, inst_valid=0); only redirect_valid or rst leaves HALT.
REQ-030 Without FETCH_HALT_EN, opcode 4'b1111 SHALL be fetched and presented like any other opcode, and no HALT state SHALL exist.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, instruction field bit positions, INST_W=16, and the HALT opcode constant.
REQ-032 One sub-module, fetch_pc_reg, SHALL hold pc with increment, wrap and redirect priority; decode slicing stays in fetch_unit.

Verification
REQ-033 Reset release, memory acks each request after 1 cycle, inst_ready=1 -> addresses 0,1,2 fetched; inst_valid for word 0x1234 gives opcode=1, rd=2, rs1=3, rs2=4.
REQ-034 inst_ready=0 for 5 cycles during HOLD -> outputs and inst_valid stable; imem_req=0 throughout.
REQ-035 ADDR_W=8, pc=0xFF, handshake -> next imem_addr=0x00.
REQ-036 Redirect to 0x40 while waiting 3 cycles for ack -> acked word not presented; next request at 0x40; inst_pc=0x40.
REQ-037 Redirect and ack in the same cycle -> no inst_valid; next cycle imem_addr=redirect_pc.
REQ-038 With FETCH_HALT_EN, 0xF000 handshaked -> imem_req stays 0; redirect to 0x10 -> fetch resumes at 0x10. Without FETCH_HALT_EN, the next fetch is at pc+1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, instruction field
// positions, instruction width and the halt opcode.
// Optional feature macro: FETCH_HALT_EN (adds the HALT state).
package fetch_unit_pkg;

  localparam int INST_W  = 16;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  localparam logic [3:0] HALT_OP = 4'hF;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect wins over increment, increment wraps
// modulo 2^ADDR_W.
module fetch_pc_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              redir,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // pc update: redirect target, else next sequential address
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pc <= RESET_PC;
    else if (redir) pc <= redir_pc;
    else if (inc)   pc <= pc + ONE;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one 16-bit word at a time from
// instruction memory, holds it decoded until the next stage accepts it,
// and handles redirects (including ones that land mid-request).
// Optional feature macro: FETCH_HALT_EN -- opcode 4'hF parks the fetcher in
// HALT until a redirect or reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [ADDR_W-1:0] inst_pc
);

  fetch_state_e      state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic [ADDR_W-1:0] kill_addr;
  logic [INST_W-1:0] ir;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              hs;
  logic              accept;

  // Downstream handshake on the held instruction
  assign hs     = (state == ST_HOLD) & inst_ready;
  // A returning word is kept only if nothing invalidated it
  assign accept = (state == ST_REQ) & imem_ack & ~kill & ~redirect_valid;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc      (hs),
    .redir    (redirect_valid),
    .redir_pc (redirect_pc),
    .pc       (pc)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = ST_REQ;
      ST_REQ:  if (accept) state_nx = ST_HOLD;
      ST_HOLD: begin
        if (redirect_valid) state_nx = ST_REQ;
`ifdef FETCH_HALT_EN
        else if (inst_ready && ir[OP_MSB:OP_LSB] == HALT_OP) state_nx = ST_HALT;
`endif
        else if (inst_ready) state_nx = ST_REQ;
      end
`ifdef FETCH_HALT_EN
      ST_HALT: if (redirect_valid) state_nx = ST_REQ;
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs; a killed request keeps presenting its original address
  always_comb begin
    imem_req   = (state == ST_REQ);
    inst_valid = (state == ST_HOLD);
    imem_addr  = kill ? kill_addr : pc;
  end

  // Kill flag: a redirect arrived while a request was outstanding, so the
  // eventual ack carries a stale word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill      <= 1'b0;
      kill_addr <= RESET_PC;
    end else if (state == ST_REQ) begin
      if (imem_ack) begin
        kill <= 1'b0;
      end else if (redirect_valid) begin
        kill <= 1'b1;
        if (!kill) kill_addr <= pc;
      end
    end
  end

  // Instruction register and its address, loaded on an accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= '0;
      inst_pc_q <= RESET_PC;
    end else if (accept) begin
      ir        <= imem_rdata;
      inst_pc_q <= pc;
    end
  end

  assign opcode  = ir[OP_MSB:OP_LSB];
  assign rd      = ir[RD_MSB:RD_LSB];
  assign rs1     = ir[RS1_MSB:RS1_LSB];
  assign rs2     = ir[RS2_MSB:RS2_LSB];
  assign inst_pc = inst_pc_q;

endmodule
